// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Constants shared by the ALU and the multi-cycle divider that feeds its
// HI/LO result path.
//   DIV_BITS         : default operand width of the divider
//   IDLE/CALC/FIX/DONE : divider FSM state encodings
//   DIV_ZERO_QUOT    : quotient reported for a divide by zero (all ones)
//   ALU_CTRL_DIV_BIT : ALU control-word bit that selects DIV
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DIV_BITS = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [DIV_BITS-1:0] DIV_ZERO_QUOT = '1;

  // ALU and seq_div decode the DIV operation from the same control bit.
  localparam int ALU_CTRL_DIV_BIT = 4;

endpackage

// File: rtl/twos_negate.sv
// -----------------------------------------------------------------------------
// twos_negate
// BITS-wide conditional two's-complement negate: out = neg ? -in : in.
// Ports:
//   in_val  [BITS-1:0] value to (maybe) negate
//   neg                1 = negate
//   out_val [BITS-1:0] result (wraps for the most negative value)
// -----------------------------------------------------------------------------
module twos_negate #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] in_val,
  input  logic            neg,
  output logic [BITS-1:0] out_val
);

  assign out_val = neg ? (~in_val + 1'b1) : in_val;

endmodule

// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div
// Multi-cycle divider producing {HI, LO} = {remainder, quotient} for the ALU's
// DIV operation. Radix-2 restoring division on magnitudes, one quotient bit per
// clock, followed by a sign-fix cycle. Quotient truncates toward zero and the
// remainder takes the dividend's sign.
// Ports:
//   clk          rising-edge clock
//   clr          asynchronous active-high reset
//   start        request pulse, sampled only in IDLE
//   is_signed    1 = signed divide (only honoured with SEQ_DIV_UNSIGNED_EN)
//   X, Y         dividend / divisor, sampled on the accepting edge
//   OpResult_HI  remainder (registered)
//   OpResult_LO  quotient (registered)
//   busy         high in CALC and FIX
//   done         one-cycle completion pulse
//   div_zero     set together with done when Y == 0
// Configuration macro:
//   SEQ_DIV_UNSIGNED_EN  when defined, is_signed=0 divides as unsigned;
//                        when undefined every operation is signed.
// -----------------------------------------------------------------------------
module seq_div
  import alu_pkg::*;
#(
  parameter int BITS  = DIV_BITS,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            is_signed,
  input  logic [BITS-1:0] X,
  input  logic [BITS-1:0] Y,
  output logic [BITS-1:0] OpResult_HI,
  output logic [BITS-1:0] OpResult_LO,
  output logic            busy,
  output logic            done,
  output logic            div_zero
);

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [BITS-1:0]  quot_q,     quot_d;     // dividend shifts out as quotient shifts in
  logic [BITS-1:0]  rem_q,      rem_d;      // partial remainder; also holds X on divide by zero
  logic [BITS-1:0]  divisor_q,  divisor_d;  // |Y|
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q,  rem_neg_d;
  logic             zero_pend_q, zero_pend_d;
  logic [BITS-1:0]  lo_q,       lo_d;
  logic [BITS-1:0]  hi_q,       hi_d;
  logic             done_q,     done_d;
  logic             dz_q,       dz_d;

  logic            eff_signed;
  logic            neg_x, neg_y;
  logic [BITS-1:0] abs_x, abs_y, quot_fix, rem_fix;
  logic [BITS:0]   rem_shift, rem_sub;

`ifdef SEQ_DIV_UNSIGNED_EN
  assign eff_signed = is_signed;
`else
  // Always signed; OR-ing keeps the unused request bit referenced.
  assign eff_signed = is_signed | 1'b1;
`endif

  assign neg_x = eff_signed & X[BITS-1];
  assign neg_y = eff_signed & Y[BITS-1];

  twos_negate #(.BITS(BITS)) u_abs_x    (.in_val(X),      .neg(neg_x),      .out_val(abs_x));
  twos_negate #(.BITS(BITS)) u_abs_y    (.in_val(Y),      .neg(neg_y),      .out_val(abs_y));
  twos_negate #(.BITS(BITS)) u_quot_fix (.in_val(quot_q), .neg(quot_neg_q), .out_val(quot_fix));
  twos_negate #(.BITS(BITS)) u_rem_fix  (.in_val(rem_q),  .neg(rem_neg_q),  .out_val(rem_fix));

  // The shifted remainder needs BITS+1 bits; after a restoring step it is
  // always below |Y|, so the stored remainder fits in BITS bits.
  assign rem_shift = {rem_q, quot_q[BITS-1]};
  assign rem_sub   = rem_shift - {1'b0, divisor_q};

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    divisor_d   = divisor_q;
    quot_neg_d  = quot_neg_q;
    rem_neg_d   = rem_neg_q;
    zero_pend_d = zero_pend_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    done_d      = 1'b0;
    dz_d        = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (Y != '0) begin
            quot_d     = abs_x;
            divisor_d  = abs_y;
            rem_d      = '0;
            cnt_d      = '0;
            quot_neg_d = neg_x ^ neg_y;
            rem_neg_d  = neg_x;
            state_d    = CALC;
          end else begin
            // Park X for the HI result; outputs are written from DONE.
            rem_d       = X;
            zero_pend_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      CALC: begin
        if (!rem_sub[BITS]) begin
          rem_d  = rem_sub[BITS-1:0];
          quot_d = {quot_q[BITS-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift[BITS-1:0];
          quot_d = {quot_q[BITS-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BITS - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = quot_fix;
        hi_d    = rem_fix;
        done_d  = 1'b1;
        dz_d    = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (zero_pend_q) begin
          // Divide by zero reports one edge after acceptance, then leaves.
          lo_d        = BITS'(DIV_ZERO_QUOT);
          hi_d        = rem_q;
          dz_d        = 1'b1;
          done_d      = 1'b1;
          zero_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      zero_pend_q <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      divisor_q   <= divisor_d;
      quot_neg_q  <= quot_neg_d;
      rem_neg_q   <= rem_neg_d;
      zero_pend_q <= zero_pend_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
    end
  end

  assign OpResult_LO = lo_q;
  assign OpResult_HI = hi_q;
  assign done        = done_q;
  assign div_zero    = dz_q;
  assign busy        = (state_q == CALC) || (state_q == FIX);

endmodule

// File: tb/tb_seq_div.sv
// -----------------------------------------------------------------------------
// tb_seq_div
// Scoreboard bench for seq_div: stimulus pushes expected {LO, HI, div_zero}
// into a queue, a monitor pops and compares on every done pulse. Random
// operands are checked against a magnitude-based reference model.
// -----------------------------------------------------------------------------
module tb_seq_div;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        is_signed;
  logic [31:0] X, Y;
  logic [31:0] OpResult_HI, OpResult_LO;
  logic        busy, done, div_zero;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb_q[$];

  seq_div dut (
    .clk(clk), .clr(clr), .start(start), .is_signed(is_signed),
    .X(X), .Y(Y), .OpResult_HI(OpResult_HI), .OpResult_LO(OpResult_LO),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: divide magnitudes in 64-bit arithmetic, then apply signs.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input bit sgn);
    exp_t        e;
    logic [63:0] ax, ay, q, r;
    bit          nx, ny;
    if (y == 32'd0) begin
      e.lo = 32'hFFFF_FFFF; e.hi = x; e.dz = 1'b1;
      return e;
    end
    nx = sgn && x[31];
    ny = sgn && y[31];
    ax = nx ? (64'd4294967296 - {32'd0, x}) : {32'd0, x};
    ay = ny ? (64'd4294967296 - {32'd0, y}) : {32'd0, y};
    q  = ax / ay;
    r  = ax % ay;
    e.lo = q[31:0];
    e.hi = r[31:0];
    if (nx ^ ny) e.lo = -e.lo;
    if (nx)      e.hi = -e.hi;
    e.dz = 1'b0;
    return e;
  endfunction

  function automatic bit eff_sgn(input bit s);
`ifdef SEQ_DIV_UNSIGNED_EN
    return s;
`else
    return 1'b1 | s;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!clr && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_lo", {32'd0, OpResult_LO}, {32'd0, e.lo});
        check("result_hi", {32'd0, OpResult_HI}, {32'd0, e.hi});
        check("div_zero",  {63'd0, div_zero},    {63'd0, e.dz});
      end
    end
  end

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input bit sgn,
                        input bit push, input exp_t e, output int s);
    @(negedge clk);
    X = x; Y = y; is_signed = sgn; start = 1'b1;
    if (push) sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    s = cyc;
  endtask

  // Waits for done, checking latency from the accepting edge and the number
  // of busy cycles; optionally pulses a second start while the first runs.
  task automatic await_done(input int s, input int lat, input int busy_exp, input int inject_at);
    int n_busy = 0;
    bit seen   = 1'b0;
    int dcyc   = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (inject_at > 0 && i == inject_at) begin
        start = 1'b1; X = 32'd9; Y = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end else if (busy) begin
        n_busy++;
      end
    end
    start = 1'b0;
    check("done_seen", {63'd0, seen}, 64'd1);
    if (seen) check("latency", 64'(dcyc - s), 64'(lat));
    check("busy_cycles", 64'(n_busy), 64'(busy_exp));
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit sgn, input exp_t e);
    int s;
    launch(x, y, sgn, 1'b1, e, s);
    if (e.dz) await_done(s, 1, 0, 0);
    else      await_done(s, 33, 33, 0);
  endtask

  function automatic exp_t mk(input logic [31:0] lo, input logic [31:0] hi, input logic dz);
    exp_t e;
    e.lo = lo; e.hi = hi; e.dz = dz;
    return e;
  endfunction

  initial begin
    int s;
    clr = 1'b1; start = 1'b0; is_signed = 1'b1; X = '0; Y = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {OpResult_HI, OpResult_LO}, 64'd0);
    check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    clr = 1'b0;

    // Sign combinations.
    run_op(32'd15,  32'd5,  1'b1, mk(32'd3,  32'd0,  1'b0));
    run_op(-32'd15, 32'd5,  1'b1, mk(-32'd3, 32'd0,  1'b0));
    run_op(32'd15,  -32'd5, 1'b1, mk(-32'd3, 32'd0,  1'b0));
    run_op(-32'd15, -32'd5, 1'b1, mk(32'd3,  32'd0,  1'b0));
    run_op(-32'd17, 32'd5,  1'b1, mk(-32'd3, -32'd2, 1'b0));

    // Divide by zero, then a normal divide clears the flag.
    run_op(32'd15, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'd15, 1'b1));
    run_op(32'd16, 32'd2, 1'b1, mk(32'd8, 32'd0, 1'b0));

    // Most negative / -1 wraps without a flag.
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0, 1'b0));

    // Start while busy is ignored: only one done, for 100/7.
    launch(32'd100, 32'd7, 1'b1, 1'b1, mk(32'd14, 32'd2, 1'b0), s);
    await_done(s, 33, 33, 10);
    repeat (40) @(negedge clk);

    // Reset mid-operation aborts; monitor flags any stray done.
    launch(32'd100, 32'd7, 1'b1, 1'b0, mk(32'd0, 32'd0, 1'b0), s);
    repeat (20) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check("abort_outputs", {OpResult_HI, OpResult_LO}, 64'd0);
    check("abort_flags", {61'd0, busy, done, div_zero}, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    run_op(32'd16, 32'd2, 1'b1, mk(32'd8, 32'd0, 1'b0));

    // Unsigned request: honoured only when the optional feature is built in.
    run_op(32'hFFFF_FFF1, 32'd5, 1'b0, model(32'hFFFF_FFF1, 32'd5, eff_sgn(1'b0)));
    run_op(32'hFFFF_FFF1, 32'd5, 1'b1, mk(-32'd3, 32'd0, 1'b0));

    // Randomized operands against the reference model.
    for (int k = 0; k < 24; k++) begin
      logic [31:0] x, y;
      bit          sg;
      int          pick;
      x    = $urandom;
      pick = $urandom_range(0, 4);
      case (pick)
        0:       y = $urandom;
        1:       y = $urandom_range(0, 9);
        2:       y = -$urandom_range(1, 9);
        3:       y = $urandom >> $urandom_range(0, 31);
        default: y = 32'd0;
      endcase
      sg = 1'($urandom_range(0, 1));
      run_op(x, y, sg, model(x, y, eff_sgn(sg)));
    end

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Multi-cycle signed 32-bit divider that sits directly upstream of the ALU result path.
- Produces the 64-bit {HI, LO} pair that the ALU's DIV operation drives onto OpResult_HI/OpResult_LO: LO = quotient, HI = remainder.
- Uses a radix-2 restoring algorithm on magnitudes, one quotient bit per clock, so the combinational ALU never contains a 32-bit array divider.

Parameters:
- BITS, 32, operand width; quotient and remainder are each BITS wide.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > BITS.

Ports:
- clk  in  1  system clock, rising-edge.
- clr  in  1  asynchronous active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- is_signed  in  1  1 = signed divide, 0 = unsigned; honoured only with the optional feature.
- X  in  BITS  dividend; sampled on the accepting edge only.
- Y  in  BITS  divisor; sampled on the accepting edge only.
- OpResult_HI  out  BITS  remainder, registered.
- OpResult_LO  out  BITS  quotient, registered.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  registered; set with done when Y == 0.

Behaviour:
- Reset (clr=1, async): state=IDLE, OpResult_HI=0, OpResult_LO=0, busy=0, done=0, div_zero=0, counter=0. Reset during CALC/FIX aborts the operation; nothing is written.
- States: IDLE, CALC, FIX, DONE. busy = (state==CALC || state==FIX).
- IDLE, start=1 at edge N:
  - Y != 0: latch |X|, |Y|, sign_q = X[BITS-1]^Y[BITS-1], sign_r = X[BITS-1]; clear partial remainder R (BITS+1 bits) and counter; go to CALC.
  - Y == 0: go straight to DONE with LO = all ones, HI = X, div_zero=1.
- CALC, one iteration per edge (edges N+1..N+32):
  - R = {R[BITS-1:0], Qreg[MSB]}; Qreg shifts left.
  - If R >= |Y|: R -= |Y|, new Qreg LSB = 1; otherwise new Qreg LSB = 0.
  - Counter increments; when counter == BITS-1, go to FIX.
- FIX, edge N+33:
  - OpResult_LO = sign_q ? -Qreg : Qreg.
  - OpResult_HI = sign_r ? -R[BITS-1:0] : R[BITS-1:0].
  - done=1, div_zero=0; go to DONE.
- DONE: next edge returns to IDLE and clears done. Normal latency: done high in the cycle after edge N+33. Divide-by-zero latency: done high after edge N+1.
- Start while busy or in DONE is ignored, with no queueing. Start in the same cycle that done is high is ignored.
- Result semantics:
  - Quotient truncates toward zero; remainder takes the dividend's sign (matches Verilog / and %).
  - Magnitudes are computed as BITS-bit unsigned, so -2^31 / -1 gives LO = 32'h80000000 (wrap), HI = 0. No overflow flag.
- Outputs hold the last result until the next completion. X and Y may change freely after the accepting edge.

Optional Feature:
- Macro: SEQ_DIV_UNSIGNED_EN.
- Defined: is_signed=0 skips the abs/negate steps (sign_q = sign_r = 0) and operands are treated as unsigned. Example: X=32'hFFFFFFF1 (4294967281), Y=5 → LO=858993456, HI=1.
- Undefined: is_signed is ignored and every operation is signed.
- Latency is identical in both builds.

Decomposition:
- alu_pkg:
  - BITS default.
  - State encodings IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
  - DIV_ZERO_QUOT constant (all ones).
  - The ALU control bit index for DIV, so that the ALU and seq_div agree.
- Sub-module twos_negate (BITS-wide conditional negate: out = neg ? -in : in). Instantiated four times: |X|, |Y|, quotient fix, remainder fix.

Test Plan:
- Sign combinations, one start each: X=15/Y=5 → LO=3, HI=0; X=-15/Y=5 → LO=-3, HI=0; X=15/Y=-5 → LO=-3, HI=0; X=-15/Y=-5 → LO=3, HI=0. Also X=-17/Y=5 → LO=-3, HI=-2. Check done exactly 33 edges after the start edge and busy high throughout CALC/FIX.
- Divide by zero: X=15, Y=0 → done after 1 edge, div_zero=1, LO=32'hFFFFFFFF, HI=15. A following 16/2 → LO=8, HI=0, div_zero=0.
- Overflow: X=-2147483648, Y=-1 → LO=32'h80000000, HI=0, done, no flag.
- Start while busy: start 100/7, then pulse start with 9/3 at cycle 10 → exactly one done, LO=14, HI=2.
- Reset mid-operation: assert clr at cycle 20 of 100/7 → outputs, busy and done all 0 immediately; no done pulse. A fresh 16/2 afterwards → LO=8, HI=0.
- SEQ_DIV_UNSIGNED_EN defined, is_signed=0, X=32'hFFFFFFF1, Y=5 → LO=858993456, HI=1. Same operands with is_signed=1 → LO=-3, HI=0.
